// File: rtl/hc_161_counter.sv
// Presettable synchronous binary counter in the style of the 74HC161, with
// asynchronous clear and a ripple-carry output for cascading.
module hc_161_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             LD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic             all_ones_s;

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    q_d = q_q;
    if (!LD) begin
      q_d = D;
    end else if (ENP && ENT) begin
      q_d = q_q + WIDTH'(1);
    end else begin
      q_d = q_q;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Carry is combinational so a cascade sees ENT changes without latency;
  // it is 0 under reset because the cleared state is never all ones.
  assign all_ones_s = &q_q;
  assign RCO        = ENT & all_ones_s;
  assign Q          = q_q;

endmodule

// Behavioural checks for one counter instance; instantiated alongside the
// design in simulation only.
module hc_161_counter_chk #(
  parameter int WIDTH = 4
) (
  input logic             Clk,
  input logic             R,
  input logic             LD,
  input logic             ENP,
  input logic             ENT,
  input logic [WIDTH-1:0] D,
  input logic [WIDTH-1:0] Q,
  input logic             RCO
);

  logic [WIDTH-1:0] q_inc_s;
  assign q_inc_s = Q + WIDTH'(1);

  a_rco_def: assert property (@(negedge Clk) RCO == (ENT && (&Q)));

  a_reset_clear: assert property (@(posedge Clk) !R |-> Q == '0);

  a_load: assert property (@(posedge Clk) disable iff (!R)
    !LD |=> Q == $past(D));

  a_count: assert property (@(posedge Clk) disable iff (!R)
    (LD && ENP && ENT) |=> Q == $past(q_inc_s));

  a_hold: assert property (@(posedge Clk) disable iff (!R)
    (LD && !(ENP && ENT)) |=> Q == $past(Q));

endmodule
